// File: rtl/xdma_req_dispatcher.sv
// xdma_req_dispatcher
// Queues DMA write requests in a small FIFO and hands them one at a time to a
// downstream write-beat tracker: a one-cycle start pulse, a wait for the
// tracker's done pulse, then a completion handshake carrying the request ID.
// Zero-length requests skip the tracker and complete directly.
// Optional feature: define XDMA_DISPATCH_TIMEOUT_EN to build a watchdog that
// aborts a WAIT lasting TimeoutCycles and reports it with cmpl_err_o = 1.
module xdma_req_dispatcher #(
  parameter type         id_t            = logic,
  parameter type         len_t           = logic,
  parameter type         xdma_req_meta_t = logic,
  parameter int unsigned Depth           = 4,
  parameter int unsigned TimeoutCycles   = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  xdma_req_meta_t         req_meta_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  output xdma_req_meta_t         write_req_meta_o,
  output logic                   write_req_busy_o,
  input  logic                   write_req_done_i,
  output logic                   cmpl_valid_o,
  input  logic                   cmpl_ready_i,
  output id_t                    cmpl_id_o,
  output logic                   cmpl_err_o,
  output logic [$clog2(Depth):0] fifo_cnt_o
);

  localparam int unsigned PtrW  = $clog2(Depth);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned IdW   = $bits(id_t);
  localparam int unsigned LenW  = $bits(len_t);
  localparam int unsigned MetaW = IdW + LenW;
  localparam int unsigned RawW  = $bits(xdma_req_meta_t);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_REPORT
  } state_e;

  // ---------------------------------------------------------------------------
  // Request FIFO
  // ---------------------------------------------------------------------------
  xdma_req_meta_t  mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            push, pop, empty;

  xdma_req_meta_t  head;
  logic [RawW-1:0] head_raw;
  logic [MetaW-1:0] head_bits;
  logic [IdW-1:0]  head_id;
  logic [LenW-1:0] head_len;

  assign empty       = (cnt_q == '0);
  assign req_ready_o = (cnt_q < CntW'(Depth));
  assign push        = req_valid_i && req_ready_o;
  assign fifo_cnt_o  = cnt_q;

  // Head fields, with dma_id in the upper bits as laid out by the packed struct.
  assign head      = mem_q[rd_ptr_q];
  assign head_raw  = head;
  assign head_bits = MetaW'(head_raw);
  assign head_id   = head_bits[MetaW-1 -: IdW];
  assign head_len  = head_bits[LenW-1:0];

  assign write_req_meta_o = empty ? '0 : head;

  // Storage write on push.
  // NOTE: the storage array has no reset; nothing reads an entry before it is
  // written, and the empty-gated head output keeps stale data invisible.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= req_meta_i;
  end

  // FIFO pointer and occupancy next-state; pointers wrap naturally (power-of-2 Depth).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO pointer and occupancy registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Dispatch FSM
  // ---------------------------------------------------------------------------
  state_e state_q, state_d;
  id_t    cmpl_id_q, cmpl_id_d;
  logic   zero_len_q, zero_len_d;
  logic   err_q, err_d;

`ifdef XDMA_DISPATCH_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TimeoutCycles) + 1;
  logic [WdW-1:0] wd_q, wd_d;
`endif

  // Next-state and pop decision; a head is popped on done (or timeout), or on
  // the completion handshake when it was a zero-length request.
  // NOTE: every signal gets a default first so no path leaves one unassigned
  // (which would infer a latch).
  always_comb begin
    state_d    = state_q;
    cmpl_id_d  = cmpl_id_q;
    zero_len_d = zero_len_q;
    err_d      = err_q;
    pop        = 1'b0;
`ifdef XDMA_DISPATCH_TIMEOUT_EN
    wd_d       = wd_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          if (head_len == '0) begin
            cmpl_id_d  = id_t'(head_id);
            err_d      = 1'b0;
            zero_len_d = 1'b1;
            state_d    = S_REPORT;
          end else begin
            zero_len_d = 1'b0;
            state_d    = S_START;
          end
        end
      end
      S_START: begin
        state_d = S_WAIT;
`ifdef XDMA_DISPATCH_TIMEOUT_EN
        wd_d    = '0;
`endif
      end
      S_WAIT: begin
        if (write_req_done_i) begin
          pop       = 1'b1;
          cmpl_id_d = id_t'(head_id);
          err_d     = 1'b0;
          state_d   = S_REPORT;
`ifdef XDMA_DISPATCH_TIMEOUT_EN
        end else if (wd_q == WdW'(TimeoutCycles - 1)) begin
          pop       = 1'b1;
          cmpl_id_d = id_t'(head_id);
          err_d     = 1'b1;
          state_d   = S_REPORT;
        end else begin
          wd_d = wd_q + 1'b1;
`endif
        end
      end
      S_REPORT: begin
        if (cmpl_ready_i) begin
          pop     = zero_len_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM and completion registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      cmpl_id_q  <= '0;
      zero_len_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmpl_id_q  <= cmpl_id_d;
      zero_len_q <= zero_len_d;
      err_q      <= err_d;
    end
  end

`ifdef XDMA_DISPATCH_TIMEOUT_EN
  // Watchdog counter, cleared on entry to WAIT.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) wd_q <= '0;
    else         wd_q <= wd_d;
  end
  assign cmpl_err_o = err_q;
`else
  // Without the watchdog no error can be reported.
  logic unused_timeout;
  logic unused_err;
  assign unused_timeout = ^TimeoutCycles;
  assign unused_err     = err_q;
  assign cmpl_err_o     = 1'b0;
`endif

  assign write_req_busy_o = (state_q == S_START);
  assign cmpl_valid_o     = (state_q == S_REPORT);
  assign cmpl_id_o        = cmpl_id_q;

endmodule

// File: tb/tb_xdma_req_dispatcher.sv
// Self-checking bench for xdma_req_dispatcher: directed scenarios with literal
// expectations, then randomized traffic, all shadowed by a transaction-level
// model (request queue plus the dispatcher's current transaction phase).
`timescale 1ns/1ps
module tb_xdma_req_dispatcher;

  typedef logic [3:0] id_t;
  typedef logic [7:0] len_t;
  typedef struct packed { id_t dma_id; len_t dma_length; } meta_t;

  localparam int Depth         = 4;
  localparam int TimeoutCycles = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  meta_t      req_meta = '0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  meta_t      wr_meta;
  logic       busy;
  logic       done = 1'b0;
  logic       cmpl_valid;
  logic       cmpl_ready = 1'b0;
  id_t        cmpl_id;
  logic       cmpl_err;
  logic [2:0] fifo_cnt;

  always #5 clk = ~clk;

  xdma_req_dispatcher #(
    .id_t            (id_t),
    .len_t           (len_t),
    .xdma_req_meta_t (meta_t),
    .Depth           (Depth),
    .TimeoutCycles   (TimeoutCycles)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .req_meta_i       (req_meta),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .write_req_meta_o (wr_meta),
    .write_req_busy_o (busy),
    .write_req_done_i (done),
    .cmpl_valid_o     (cmpl_valid),
    .cmpl_ready_i     (cmpl_ready),
    .cmpl_id_o        (cmpl_id),
    .cmpl_err_o       (cmpl_err),
    .fifo_cnt_o       (fifo_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Transaction-level model
  // ---------------------------------------------------------------------------
  typedef enum {M_FREE, M_ISSUED, M_AWAIT, M_REPORT} phase_e;

  meta_t  q[$];
  phase_e ph = M_FREE;
  bit     seen_idle = 1'b0;   // previous cycle was an idle look at a non-empty queue
  id_t    exp_id = '0;
  bit     exp_err = 1'b0;
  bit     zl = 1'b0;
  int     wc = 0;
  int     busy_seen = 0;
  int     cmpl_seen = 0;

  always @(negedge clk) begin : cmp
    meta_t exp_meta;
    bit    exp_busy, exp_valid, do_push, do_pop, idle_n;
    if (!rst_n) begin
      check("rst_cnt",   32'(fifo_cnt),   32'd0);
      check("rst_ready", 32'(req_ready),  32'd1);
      check("rst_busy",  32'(busy),       32'd0);
      check("rst_valid", 32'(cmpl_valid), 32'd0);
      check("rst_id",    32'(cmpl_id),    32'd0);
      check("rst_err",   32'(cmpl_err),   32'd0);
      check("rst_meta",  32'(wr_meta),    32'd0);
      q.delete();
      ph        = M_FREE;
      seen_idle = 1'b0;
    end else begin
      exp_meta = (q.size() != 0) ? q[0] : '0;
      check("cnt",   32'(fifo_cnt),  32'(q.size()));
      check("ready", 32'(req_ready), 32'(q.size() < Depth));
      check("meta",  32'(wr_meta),   32'(exp_meta));

      exp_busy  = 1'b0;
      exp_valid = 1'b0;
      idle_n    = (ph == M_FREE) && (q.size() != 0) && !seen_idle;
      // One idle look at the queue, then the head is dispatched.
      if (ph == M_FREE && seen_idle && q.size() != 0) begin
        if (q[0].dma_length != 0) begin
          exp_busy = 1'b1;
          ph       = M_ISSUED;
        end else begin
          exp_id  = q[0].dma_id;
          exp_err = 1'b0;
          zl      = 1'b1;
          ph      = M_REPORT;
        end
      end
      if (ph == M_REPORT) exp_valid = 1'b1;
      check("busy",  32'(busy),       32'(exp_busy));
      check("valid", 32'(cmpl_valid), 32'(exp_valid));
      if (exp_valid) begin
        check("cmpl_id",  32'(cmpl_id),  32'(exp_id));
        check("cmpl_err", 32'(cmpl_err), 32'(exp_err));
      end
      if (busy) busy_seen++;
      if (cmpl_valid && cmpl_ready) cmpl_seen++;

      // Events taking effect at the coming rising edge.
      do_push = req_valid && (q.size() < Depth);
      do_pop  = 1'b0;
      if (ph == M_ISSUED) begin
        ph = M_AWAIT;
        wc = 0;
      end else if (ph == M_AWAIT) begin
        if (done) begin
          do_pop  = 1'b1;
          exp_id  = q[0].dma_id;
          exp_err = 1'b0;
          zl      = 1'b0;
          ph      = M_REPORT;
        end else begin
          wc++;
`ifdef XDMA_DISPATCH_TIMEOUT_EN
          if (wc == TimeoutCycles) begin
            do_pop  = 1'b1;
            exp_id  = q[0].dma_id;
            exp_err = 1'b1;
            zl      = 1'b0;
            ph      = M_REPORT;
          end
`endif
        end
      end else if (ph == M_REPORT && cmpl_ready) begin
        do_pop = zl;
        ph     = M_FREE;
      end
      if (do_pop) q.delete(0);
      if (do_push) q.push_back(req_meta);
      seen_idle = idle_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_req(input id_t id, input len_t len);
    int b;
    bit ok;
    b = 0;
    req_meta.dma_id     = id;
    req_meta.dma_length = len;
    req_valid = 1'b1;
    do begin
      ok = req_ready;
      step();
      b++;
    end while (!ok && b < 200);
    req_valid = 1'b0;
    check("push_accepted", 32'(ok), 32'd1);
  endtask

  task automatic wait_busy(input int budget);
    int b;
    b = 0;
    while (!busy && b < budget) begin
      step();
      b++;
    end
    check("busy_within_budget", 32'(busy), 32'd1);
  endtask

  task automatic wait_valid(input int budget);
    int b;
    b = 0;
    while (!cmpl_valid && b < budget) begin
      step();
      b++;
    end
    check("valid_within_budget", 32'(cmpl_valid), 32'd1);
  endtask

  initial begin : watchdog
    #1ms;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "global timeout");
  end

  initial begin : drive
    int b0, b1, c0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Single request, done 6 cycles after the start pulse.
    cmpl_ready = 1'b1;
    b0 = busy_seen;
    push_req(4'd5, 8'd4);
    wait_busy(20);
    repeat (6) step();
    done = 1'b1;
    step();
    done = 1'b0;
    wait_valid(10);
    check("single_id",  32'(cmpl_id),  32'd5);
    check("single_err", 32'(cmpl_err), 32'd0);
    repeat (2) step();
    check("single_cnt",   32'(fifo_cnt),      32'd0);
    check("single_pulse", 32'(busy_seen - b0), 32'd1);

    // Fill the FIFO with done stalled, then a fifth request.
    b0 = busy_seen;
    c0 = cmpl_seen;
    for (int i = 1; i <= 4; i++) push_req(4'(i), 8'd3);
    check("full_ready", 32'(req_ready), 32'd0);
    check("full_cnt",   32'(fifo_cnt),  32'd4);
    req_meta.dma_id     = 4'd5;
    req_meta.dma_length = 8'd3;
    req_valid = 1'b1;
    repeat (3) step();
    check("full_hold_cnt", 32'(fifo_cnt), 32'd4);
    done = 1'b1;
    push_req(4'd5, 8'd3);
    repeat (40) step();
    done = 1'b0;
    check("fill_drain_cnt",   32'(fifo_cnt),       32'd0);
    check("fill_pulses",      32'(busy_seen - b0), 32'd5);
    check("fill_completions", 32'(cmpl_seen - c0), 32'd5);

    // Zero-length request.
    b0 = busy_seen;
    push_req(4'd2, 8'd0);
    wait_valid(10);
    check("zl_id",  32'(cmpl_id),  32'd2);
    check("zl_err", 32'(cmpl_err), 32'd0);
    repeat (2) step();
    check("zl_no_busy", 32'(busy_seen - b0), 32'd0);

    // Completion back-pressure delays the next start.
    cmpl_ready = 1'b0;
    done = 1'b1;
    b0 = busy_seen;
    push_req(4'd7, 8'd2);
    push_req(4'd8, 8'd2);
    wait_valid(20);
    b1 = busy_seen;
    repeat (10) step();
    check("hold_valid",    32'(cmpl_valid),     32'd1);
    check("hold_id",       32'(cmpl_id),        32'd7);
    check("hold_no_start", 32'(busy_seen - b1), 32'd0);
    check("hold_cnt",      32'(fifo_cnt),       32'd1);
    cmpl_ready = 1'b1;
    repeat (20) step();
    done = 1'b0;
    check("hold_pulses", 32'(busy_seen - b0), 32'd2);
    check("hold_cnt_end", 32'(fifo_cnt), 32'd0);

    // Tracker never finishes.
    push_req(4'd9, 8'd1);
    wait_busy(20);
`ifdef XDMA_DISPATCH_TIMEOUT_EN
    wait_valid(40);
    check("timeout_id",  32'(cmpl_id),  32'd9);
    check("timeout_err", 32'(cmpl_err), 32'd1);
    repeat (2) step();
`else
    repeat (40) step();
    check("stuck_valid", 32'(cmpl_valid), 32'd0);
    check("stuck_cnt",   32'(fifo_cnt),   32'd1);
    done = 1'b1;
    step();
    done = 1'b0;
    wait_valid(10);
    check("stuck_err", 32'(cmpl_err), 32'd0);
    repeat (2) step();
`endif

    // Reset while waiting with requests queued.
    b0 = busy_seen;
    c0 = cmpl_seen;
    for (int i = 11; i <= 14; i++) push_req(4'(i), 8'd5);
    repeat (3) step();
    rst_n = 1'b0;
    repeat (3) step();
    check("inrst_cnt",   32'(fifo_cnt),  32'd0);
    check("inrst_ready", 32'(req_ready), 32'd1);
    rst_n = 1'b1;
    repeat (10) step();
    check("postrst_cmpl",  32'(cmpl_seen - c0), 32'd0);
    check("postrst_pulse", 32'(busy_seen - b0), 32'd1);
    check("postrst_valid", 32'(cmpl_valid),     32'd0);

    // Randomized traffic.
    repeat (3000) begin
      req_valid           = 1'($urandom_range(0, 1));
      req_meta.dma_id     = 4'($urandom);
      req_meta.dma_length = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      done                = ($urandom_range(0, 3) == 0);
      cmpl_ready          = ($urandom_range(0, 2) != 0);
      step();
    end
    req_valid  = 1'b0;
    done       = 1'b1;
    cmpl_ready = 1'b1;
    repeat (100) step();
    done = 1'b0;
    check("drain_cnt", 32'(fifo_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
